// File: rtl/spi_target_if.sv
// spi_target_if: SPI pad signals plus the byte-level TX/RX handshake of spi_target.
interface spi_target_if;
  logic       spi_sck;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_underrun;
  logic       busy;
  modport slave (
    input  spi_sck, spi_cs_n, spi_mosi, tx_data, tx_valid,
    output spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );
  modport master (
    output spi_sck, spi_cs_n, spi_mosi, tx_data, tx_valid,
    input  spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );
endinterface

// File: rtl/spi_target.sv
// spi_target: SPI mode 0 byte target, oversampled in clk_80, with a one-entry TX holding register.
module spi_target #(
  parameter logic [7:0] IDLE_BYTE   = 8'hFF,
  parameter int         SYNC_STAGES = 2
) (
  input logic        clk_80,
  input logic        rst,
  spi_target_if.slave bus
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d, cs_sync_q, cs_sync_d, mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] fill_q, fill_d;
  logic       sck_dly_q, cs_dly_q, armed_q, armed_d;
  logic       sck_s, cs_s, mosi_s, sck_rise, sck_fall, cs_rise, cs_fall;
  logic       busy, sck_ok, load, shift_ev, wr;
  logic [7:0] hold_q, hold_d, tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       full_q, full_d, tx_ready_q, rx_valid_q, rx_valid_d;
  logic       underrun_q, underrun_d, miso_q, miso_d, miso_oe_q, miso_oe_d;
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_dly_q;
  assign sck_fall = ~sck_s & sck_dly_q;
  assign cs_rise  = cs_s & ~cs_dly_q;
  assign cs_fall  = armed_q & ~cs_s & cs_dly_q;
  // A start needs a genuinely observed high cs_n first, so a pin held low through reset is not a start.
  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], bus.spi_sck};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], bus.spi_cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
    fill_d      = {fill_q[SYNC_STAGES-2:0], 1'b1};
    armed_d     = armed_q | (fill_q[SYNC_STAGES-1] & cs_s);
  end
  always_comb begin
    state_d = (state_q == IDLE) ? (cs_fall ? ACTIVE : IDLE) : (cs_rise ? IDLE : ACTIVE);
  end
  always_comb begin
    busy     = state_q == ACTIVE;
    sck_ok   = busy & ~cs_rise;
    load     = (~busy & cs_fall) | (sck_ok & sck_fall & bit_cnt_q == 3'd0);
    shift_ev = sck_ok & sck_fall & bit_cnt_q != 3'd0;
  end
  always_comb begin
    wr         = bus.tx_valid & tx_ready_q;
    hold_d     = wr ? bus.tx_data : hold_q;
    full_d     = wr | (full_q & ~load);
    tx_shift_d = load ? (full_q ? hold_q : IDLE_BYTE) : shift_ev ? {tx_shift_q[6:0], 1'b0} : tx_shift_q;
    underrun_d = load & ~full_q;
    miso_d     = (state_d == IDLE) ? 1'b1 : (load | shift_ev) ? tx_shift_d[7] : miso_q;
    miso_oe_d  = state_d == ACTIVE;
    bit_cnt_d  = (cs_fall | cs_rise) ? 3'd0 : (sck_ok & sck_rise) ? bit_cnt_q + 3'd1 : bit_cnt_q;
    rx_shift_d = (sck_ok & sck_rise) ? {rx_shift_q[6:0], mosi_s} : rx_shift_q;
    rx_valid_d = sck_ok & sck_rise & bit_cnt_q == 3'd7;
    rx_data_d  = rx_valid_d ? rx_shift_d : rx_data_q;
  end
  always_ff @(posedge clk_80 or posedge rst) begin
    if (rst) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      fill_q      <= '0;
      sck_dly_q   <= 1'b0;
      cs_dly_q    <= 1'b1;
      armed_q     <= 1'b0;
      state_q     <= IDLE;
      hold_q      <= 8'h00;
      full_q      <= 1'b0;
      tx_ready_q  <= 1'b1;
      tx_shift_q  <= 8'h00;
      underrun_q  <= 1'b0;
      miso_q      <= 1'b1;
      miso_oe_q   <= 1'b0;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 8'h00;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= 8'h00;
    end else begin
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      fill_q      <= fill_d;
      sck_dly_q   <= sck_s;
      cs_dly_q    <= cs_s;
      armed_q     <= armed_d;
      state_q     <= state_d;
      hold_q      <= hold_d;
      full_q      <= full_d;
      tx_ready_q  <= ~full_d;
      tx_shift_q  <= tx_shift_d;
      underrun_q  <= underrun_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
    end
  end
  assign bus.spi_miso    = miso_q;
  assign bus.spi_miso_oe = miso_oe_q;
  assign bus.tx_ready    = tx_ready_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.tx_underrun = underrun_q;
  assign bus.busy        = busy;
endmodule
